// File: rtl/arbiter_pkg.sv
// arbiter_pkg: shared states, grant codes and round-robin helpers for the three-client arbiter
package arbiter_pkg;
  localparam int NUM_CLIENTS = 3;
  localparam logic [1:0] CODE_NONE = 2'b00;
  localparam logic [1:0] CODE_C0   = 2'b11;
  localparam logic [1:0] CODE_C1   = 2'b10;
  localparam logic [1:0] CODE_C2   = 2'b01;
  // Low two state bits carry the grant code so Q1/Q0 come straight off the state flops
  typedef enum logic [2:0] {
    IDLE = {1'b0, CODE_NONE},
    GNT0 = {1'b0, CODE_C0},
    GNT1 = {1'b0, CODE_C1},
    GNT2 = {1'b0, CODE_C2},
    TURN = {1'b1, CODE_NONE}
  } state_t;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
  function automatic state_t gnt_state(input logic [1:0] i);
    return (i == 2'd0) ? GNT0 : (i == 2'd1) ? GNT1 : GNT2;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin winner search starting after the last-grant pointer
module rr_pick
  import arbiter_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [1:0]             ptr,
  output logic                   valid,
  output logic [1:0]             win
);
  logic [1:0] c1, c2, c3;
  always_comb begin
    c1 = rr_next(ptr);
    c2 = rr_next(c1);
    c3 = rr_next(c2);
    valid = |req;
    win = req[c1] ? c1 : req[c2] ? c2 : c3;
  end
endmodule

// File: rtl/arbiter_fsm.sv
// arbiter_fsm: three-client round-robin grant FSM with bounded hold and idle turnaround
module arbiter_fsm
  import arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int GAP      = 1,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_CLIENTS-1:0] req,
  output logic                   Q1,
  output logic                   Q0,
  output logic                   busy,
  output logic                   timeout
);
  state_t           state, state_nx;
  logic [1:0]       ptr, ptr_nx, cur, win;
  logic [CNT_W-1:0] hold_cnt, hold_nx, gap_cnt, gap_nx;
  logic             valid, arb, timeout_nx;

  rr_pick u_pick (
    .req  (req),
    .ptr  (ptr),
    .valid(valid),
    .win  (win)
  );

  always_comb begin
    cur = state == GNT0 ? 2'd0 : state == GNT1 ? 2'd1 : 2'd2;
    state_nx = state;
    ptr_nx = ptr;
    hold_nx = hold_cnt;
    gap_nx = gap_cnt;
    timeout_nx = 1'b0;
    arb = 1'b0;
    case (state)
      IDLE: arb = 1'b1;
      GNT0, GNT1, GNT2:
        if (req[cur] && hold_cnt < CNT_W'(MAX_HOLD)) hold_nx = hold_cnt + CNT_W'(1);
        else begin
          timeout_nx = req[cur];
          state_nx = TURN;
          gap_nx = CNT_W'(1);
          arb = GAP == 0;
        end
      TURN:
        if (gap_cnt >= CNT_W'(GAP)) arb = 1'b1;
        else gap_nx = gap_cnt + CNT_W'(1);
      default: state_nx = IDLE;
    endcase
    // Arbitration overrides the TURN entry when the gap is zero
    if (arb) begin
      state_nx = valid ? gnt_state(win) : IDLE;
      ptr_nx = valid ? win : ptr;
      hold_nx = valid ? CNT_W'(1) : hold_cnt;
      gap_nx = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 2'd2;
      hold_cnt <= '0;
      gap_cnt <= '0;
      timeout <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      hold_cnt <= hold_nx;
      gap_cnt <= gap_nx;
      timeout <= timeout_nx;
      busy <= state_nx inside {GNT0, GNT1, GNT2};
    end

  assign Q1 = state[1];
  assign Q0 = state[0];
endmodule

// File: tb/tb_arbiter_fsm.sv
// tb_arbiter_fsm: three parameterisations checked every cycle against a behavioural model
module tb_arbiter_fsm;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] req = 3'b000;
  logic [2:0] q1, q0, busy, tmo;

  always #5 clk = ~clk;

  arbiter_fsm #(.MAX_HOLD(8), .GAP(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req),
    .Q1(q1[0]), .Q0(q0[0]), .busy(busy[0]), .timeout(tmo[0]));
  arbiter_fsm #(.MAX_HOLD(3), .GAP(1), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req),
    .Q1(q1[1]), .Q0(q0[1]), .busy(busy[1]), .timeout(tmo[1]));
  arbiter_fsm #(.MAX_HOLD(3), .GAP(0), .CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req),
    .Q1(q1[2]), .Q0(q0[2]), .busy(busy[2]), .timeout(tmo[2]));

  typedef struct {
    int owner;
    int held;
    int gapl;
    int ptr;
    bit to;
  } ms_t;

  ms_t m[3];

  function automatic int mh(input int k);
    return k == 0 ? 8 : 3;
  endfunction

  function automatic int gp(input int k);
    return k == 2 ? 0 : 1;
  endfunction

  function automatic ms_t reset_ms();
    ms_t s;
    s.owner = -1;
    s.held = 0;
    s.gapl = 0;
    s.ptr = 2;
    s.to = 1'b0;
    return s;
  endfunction

  function automatic ms_t step(input ms_t si, input logic [2:0] r, input int hmax, input int gap);
    ms_t s = si;
    bit arb = 1'b0;
    s.to = 1'b0;
    if (s.owner >= 0) begin
      if (r[s.owner] && s.held < hmax) s.held++;
      else begin
        s.to = r[s.owner];
        s.owner = -1;
        s.gapl = gap;
        arb = (gap == 0);
      end
    end else if (s.gapl > 0) begin
      s.gapl--;
      arb = (s.gapl == 0);
    end else arb = 1'b1;
    if (arb)
      for (int o = 1; o <= 3; o++) begin
        int c = (s.ptr + o) % 3;
        if (r[c]) begin
          s.owner = c;
          s.ptr = c;
          s.held = 1;
          break;
        end
      end
    return s;
  endfunction

  function automatic logic [3:0] expect_of(input ms_t s);
    logic [1:0] code = s.owner == 0 ? 2'b11 : s.owner == 1 ? 2'b10 : s.owner == 2 ? 2'b01 : 2'b00;
    logic b = (s.owner >= 0);
    return {code, b, s.to};
  endfunction

  function automatic logic [3:0] dut_of(input int k);
    return {q1[k], q0[k], busy[k], tmo[k]};
  endfunction

  always @(posedge clk or negedge rst_n)
    for (int k = 0; k < 3; k++) m[k] <= !rst_n ? reset_ms() : step(m[k], req, mh(k), gp(k));

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;
  bit pin_on = 1'b0;
  int pin_k = 0;
  logic [3:0] pin_exp = 4'b0;
  string pin_nm = "";

  always @(negedge clk)
    if (run) begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (dut_of(k) !== expect_of(m[k])) begin
          errors++;
          $display("FAIL model inst%0d t=%0t got %b want %b", k, $time, dut_of(k), expect_of(m[k]));
        end
      end
      if (pin_on) begin
        checks++;
        if (dut_of(pin_k) !== pin_exp) begin
          errors++;
          $display("FAIL %s inst%0d got %b want %b", pin_nm, pin_k, dut_of(pin_k), pin_exp);
        end
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pin(input string nm, input int k, input logic [3:0] e);
    pin_nm = nm;
    pin_k = k;
    pin_exp = e;
    pin_on = 1'b1;
    @(negedge clk);
    #1 pin_on = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // pin values are {Q1,Q0,busy,timeout}
  initial begin
    #1 rst_n = 1'b0;
    #1 run = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    pin("reset_state", 0, 4'b0000);

    req = 3'b001;
    cyc(1); pin("single_first", 0, 4'b1110);
    cyc(3); pin("single_fourth", 0, 4'b1110);
    req = 3'b000;
    cyc(1); pin("single_turn", 0, 4'b0000);
    cyc(1); pin("single_idle", 0, 4'b0000);

    do_reset();
    req = 3'b111;
    cyc(1); pin("rr_c0_start", 0, 4'b1110);
    cyc(7); pin("rr_c0_end", 0, 4'b1110);
    cyc(1); pin("rr_timeout0", 0, 4'b0001);
    cyc(1); pin("rr_c1_start", 0, 4'b1010);
    cyc(8); pin("rr_timeout1", 0, 4'b0001);
    cyc(1); pin("rr_c2_start", 0, 4'b0110);
    cyc(8); pin("rr_timeout2", 0, 4'b0001);
    cyc(1); pin("rr_wrap_c0", 0, 4'b1110);

    do_reset();
    req = 3'b010;
    cyc(1); pin("pre_first", 1, 4'b1010);
    cyc(2); pin("pre_third", 1, 4'b1010);
    cyc(1); pin("pre_timeout", 1, 4'b0001);
    cyc(1); pin("pre_regrant", 1, 4'b1010);
    cyc(3); pin("pre_timeout2", 1, 4'b0001);

    do_reset();
    req = 3'b011;
    cyc(1); pin("gap0_c0", 2, 4'b1110);
    cyc(1); pin("gap0_c0_hold", 2, 4'b1110);
    req = 3'b010;
    cyc(1); pin("gap0_handover", 2, 4'b1010);
    cyc(1);
    #1 rst_n = 1'b0;
    pin("async_reset", 2, 4'b0000);
    req = 3'b000;
    cyc(3);
    rst_n = 1'b1;
    cyc(2); pin("post_reset_idle", 2, 4'b0000);

    do_reset();
    req = 3'b001;
    cyc(1); pin("fair_c0", 0, 4'b1110);
    req = 3'b000;
    cyc(1); pin("fair_turn", 0, 4'b0000);
    req = 3'b101;
    cyc(1); pin("fair_c2_first", 0, 4'b0110);

    repeat (3000) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
      end
      cyc(1);
    end
    req = 3'b000;
    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
